// File: rtl/fpga_cfg_pkg.sv
// Shared fixed-point configuration and scheduler types for the Monte-Carlo GBM datapath.
package fpga_cfg_pkg;

  localparam int FP_WIDTH            = 32;
  localparam int FP_QINT             = 16;
  localparam int GBM_SCHED_MAX_PATHS = 64;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    DRAIN
  } sched_state_e;

endpackage

// File: rtl/path_state_rf.sv
// Per-path price register file: one combinational read port, one synchronous write port.
module path_state_rf #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 64,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic [AW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  // Data words carry no reset; contents are only read after being written in the same batch.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/gbm_path_sched.sv
// Drives one shared GBM_step pipeline over a batch of paths x steps and streams tagged prices.
module gbm_path_sched
  import fpga_cfg_pkg::*;
#(
  parameter int WIDTH     = FP_WIDTH,
  parameter int QINT      = FP_QINT,
  parameter int MAX_PATHS = GBM_SCHED_MAX_PATHS,
  parameter int STEP_W    = 16,
  parameter int ISSUE_GAP = 1
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         start,
  input  logic [$clog2(MAX_PATHS):0]   n_paths,
  input  logic [STEP_W-1:0]            n_steps,
  input  logic [WIDTH-1:0]             s_init,
  input  logic [WIDTH-1:0]             r,
  input  logic [WIDTH-1:0]             sigma,
  input  logic [WIDTH-1:0]             dt,
  input  logic                         z_valid,
  input  logic [WIDTH-1:0]             z_data,
  output logic                         z_ready,
  output logic                         gbm_valid_in,
  output logic [WIDTH-1:0]             gbm_z,
  output logic [WIDTH-1:0]             gbm_s0,
  output logic [WIDTH-1:0]             gbm_r,
  output logic [WIDTH-1:0]             gbm_sigma,
  output logic [WIDTH-1:0]             gbm_t,
  input  logic                         gbm_valid_out,
  input  logic [WIDTH-1:0]             gbm_s1,
  output logic                         out_valid,
  output logic [$clog2(MAX_PATHS)-1:0] out_path,
  output logic [STEP_W-1:0]            out_step,
  output logic [WIDTH-1:0]             out_s,
  output logic                         busy,
  output logic                         done,
  output logic                         err
);

  localparam int PW    = $clog2(MAX_PATHS);
  localparam int NPW   = PW + 1;
  localparam int GAP_W = (ISSUE_GAP > 1) ? $clog2(ISSUE_GAP) : 1;

  if (ISSUE_GAP < 1 || QINT < 0 || QINT >= WIDTH) begin : g_bad_param
    $error("gbm_path_sched: ISSUE_GAP must be >= 1 and QINT within WIDTH");
  end

  sched_state_e     state, state_nxt;
  logic [STEP_W-1:0] step, n_steps_lat;
  logic [PW-1:0]    iss_idx, ret_idx;
  logic [GAP_W-1:0] gap_cnt;
  logic [NPW-1:0]   n_paths_lat;
  logic [WIDTH-1:0] s_init_lat, r_lat, sigma_lat, dt_lat, rd_data;
  logic             cfg_ok, start_ok, fire, ret_ok, last_iss, last_ret, last_step;

  assign cfg_ok    = (n_paths != '0) && (n_paths <= NPW'(MAX_PATHS)) && (n_steps != '0);
  assign start_ok  = (state == IDLE) && start && cfg_ok;
  assign z_ready   = (state == ISSUE) && (gap_cnt == '0);
  assign fire      = z_ready && z_valid;
  assign ret_ok    = (state != IDLE) && gbm_valid_out;
  assign last_iss  = ({1'b0, iss_idx} == n_paths_lat - NPW'(1));
  assign last_ret  = ({1'b0, ret_idx} == n_paths_lat - NPW'(1));
  assign last_step = (step == n_steps_lat - STEP_W'(1));

  assign gbm_valid_in = fire;
  assign gbm_z        = fire ? z_data : '0;
  assign gbm_s0       = (step == '0) ? s_init_lat : rd_data;
  assign gbm_r        = r_lat;
  assign gbm_sigma    = sigma_lat;
  assign gbm_t        = dt_lat;
  assign busy         = (state != IDLE);

  path_state_rf #(
    .WIDTH (WIDTH),
    .DEPTH (MAX_PATHS)
  ) u_rf (
    .clk   (clk),
    .we    (ret_ok),
    .waddr (ret_idx),
    .wdata (gbm_s1),
    .raddr (iss_idx),
    .rdata (rd_data)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // A step only ends once its last result is back, so the next step reads fully updated prices.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start_ok) state_nxt = ISSUE;
      ISSUE:   if (fire && last_iss) state_nxt = DRAIN;
      DRAIN:   if (ret_ok && last_ret) state_nxt = last_step ? IDLE : ISSUE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      step        <= '0;
      n_steps_lat <= '0;
      n_paths_lat <= '0;
      iss_idx     <= '0;
      ret_idx     <= '0;
      gap_cnt     <= '0;
      s_init_lat  <= '0;
      r_lat       <= '0;
      sigma_lat   <= '0;
      dt_lat      <= '0;
      out_valid   <= 1'b0;
      out_path    <= '0;
      out_step    <= '0;
      out_s       <= '0;
      done        <= 1'b0;
      err         <= 1'b0;
    end else begin
      done      <= 1'b0;
      out_valid <= 1'b0;

      if (fire) begin
        iss_idx <= iss_idx + PW'(1);
        gap_cnt <= GAP_W'(ISSUE_GAP - 1);
      end else if (gap_cnt != '0) begin
        gap_cnt <= gap_cnt - GAP_W'(1);
      end

      if (ret_ok) begin
        out_valid <= 1'b1;
        out_path  <= ret_idx;
        out_step  <= step;
        out_s     <= gbm_s1;
        ret_idx   <= last_ret ? '0 : ret_idx + PW'(1);
        if (state == DRAIN && last_ret) begin
          if (last_step) begin
            done <= 1'b1;
          end else begin
            step    <= step + STEP_W'(1);
            iss_idx <= '0;
          end
        end
      end

      if (start_ok) begin
        n_paths_lat <= n_paths;
        n_steps_lat <= n_steps;
        s_init_lat  <= s_init;
        r_lat       <= r;
        sigma_lat   <= sigma;
        dt_lat      <= dt;
        step        <= '0;
        iss_idx     <= '0;
        ret_idx     <= '0;
        gap_cnt     <= '0;
        err         <= 1'b0;
      end else if (state == IDLE && start) begin
        err <= 1'b1;
      end

      // Results arriving with no batch in flight (e.g. after a mid-batch reset) are flagged.
      if (state == IDLE && gbm_valid_out) err <= 1'b1;
    end
  end

endmodule

// File: doc/gbm_path_sched.md
# gbm_path_sched

Scheduler that drives one shared `GBM_step` pipeline across a batch of Monte-Carlo paths and time steps. It latches the batch configuration (path count, step count, S_init, r, sigma, dt) on `start`. It then issues step k for paths 0..n_paths-1 back-to-back, pulling one normal sample per issue from the QMC/Box-Muller z stream, and stores each returned price in a per-path register file. Each price is forwarded as a tagged stream to the LSM path store. Step k+1 issues only after every step-k result has returned.

## Interface
- WIDTH, 32, fixed-point word width (fpga_cfg_pkg::FP_WIDTH)
- QINT, fpga_cfg_pkg::FP_QINT, integer bits (Q16 fraction at defaults)
- MAX_PATHS, 64, register-file depth, paths per batch
- STEP_W, 16, width of step counter / n_steps
- ISSUE_GAP, 1, minimum cycles between consecutive GBM issues (≥1)
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- start  in  1  batch start pulse, sampled only in IDLE
- n_paths  in  $clog2(MAX_PATHS)+1  paths in batch, valid 1..MAX_PATHS
- n_steps  in  STEP_W  steps per path, valid ≥1
- s_init, r, sigma, dt  in  WIDTH each  signed Q config, latched on accepted start
- z_valid  in  1  z sample available
- z_data  in  WIDTH  signed normal sample
- z_ready  out  1  sample consumed this cycle when z_valid=1
- gbm_valid_in  out  1  issue to GBM_step
- gbm_z, gbm_s0, gbm_r, gbm_sigma, gbm_t  out  WIDTH each  GBM operands
- gbm_valid_out  in  1  GBM result strobe
- gbm_s1  in  WIDTH  GBM result
- out_valid  out  1  result strobe to path store (no backpressure)
- out_path  out  $clog2(MAX_PATHS)  path index
- out_step  out  STEP_W  step index, 0-based
- out_s  out  WIDTH  price
- busy  out  1  high from accepted start until batch finishes
- done  out  1  one-cycle pulse at batch completion
- err  out  1  sticky; cleared by next accepted start

## Operation
- States: IDLE, ISSUE, DRAIN.
- IDLE + start with invalid config (n_paths=0, n_paths>MAX_PATHS, or n_steps=0): no state change; err←1; done stays 0.
- IDLE + start with valid config: latch config; step←0, iss_idx←0, ret_idx←0, gap_cnt←0; err←0; →ISSUE.
- ISSUE: z_ready = (gap_cnt==0), independent of z_valid. A fire happens when z_valid && z_ready.
  - gbm_valid_in=1, gbm_z=z_data, combinational in the fire cycle.
  - gbm_s0 = (step==0) ? s_init_lat : mem[iss_idx].
  - gbm_r, gbm_sigma, gbm_t are the latched config, held constant for the whole batch.
  - On fire: iss_idx++, gap_cnt←ISSUE_GAP-1. The fire at iss_idx==n_paths-1 moves to DRAIN.
  - gap_cnt decrements to 0 while nonzero.
- Return handling, in any non-IDLE state, including ISSUE:
  - On gbm_valid_out: mem[ret_idx]←gbm_s1; emit out_* one cycle later with path=ret_idx, step=step.
  - ret_idx++ wraps to 0 after n_paths-1.
  - Results return in issue order (fixed-latency pipeline).
- DRAIN, on the last return (ret_idx==n_paths-1):
  - If step==n_steps-1, go to IDLE.
  - Otherwise step++, iss_idx←0, and go to ISSUE.
- gbm_valid_out while IDLE: ignored, err←1.
- start while busy: ignored, no error.
- Reset mid-batch: all state cleared, the in-flight GBM results that come back afterwards are flagged by err, and mem contents become don't-care.

## Timing
- Reset values: all outputs 0; state IDLE.
- Start accepted at edge T → busy=1 from T+1, and the first z_ready can assert at T+1.
- Sustained issue rate is 1 per ISSUE_GAP cycles while z_valid stays high.
- A z stall freezes issue; gap_cnt still counts down.
- out_* lag gbm_valid_out by exactly 1 cycle. Consecutive strobes produce consecutive outputs.
- For the final result at edge T: out_valid and done are high during T+1, busy=0 from T+1, and a new start is accepted at T+1.
- No read/write hazard on mem: step k+1 issues never overlap step-k returns.

## Structure
- fpga_cfg_pkg gains:
  - sched_state_e enum (IDLE, ISSUE, DRAIN).
  - GBM_SCHED_MAX_PATHS default constant.
- One sub-module, `path_state_rf`: MAX_PATHS×WIDTH register file, 1 combinational read port, 1 synchronous write port, no reset on data.

## Test plan
All values are Q16. The bench uses a stub GBM with latency 7 and s1 = s0 + 0x0001_0000.
- n_paths=4, n_steps=3, s_init=0x0064_0000, z_valid=1 always → 12 outputs.
  - Output (p,k) has out_s = 0x0064_0000 + (k+1)·0x0001_0000, order p=0..3 within each k.
  - done pulses once, with the final output.
- Same as above with ISSUE_GAP=3 → gbm_valid_in spacing is exactly 3 cycles within a step; output values are identical.
- z_valid toggling 1,0,0,1 … → gbm_valid_in occurs only on z_valid&&z_ready cycles; gbm_z equals the consumed sample; total z consumed = 12.
- start with n_paths=0 → err=1, busy stays 0. A following valid start clears err.
- Mid-batch rst_n low for 2 cycles at step 1 → all outputs 0 and state IDLE. Later stray stub returns → err=1, no out_valid.
- start held high during the batch → no restart; path/step sequence unchanged.
